// File: rtl/pulse_gen_mod.sv
// pulse_gen_mod: step-rate pulse generator with a free-running 1 Hz timebase.
// mode0Clk is a phase-accumulator square wave at the selected step rate R
// (accumulator adds 2*R per clock, so it toggles 2*R times per second).
// mode1Clk is a 1 Hz square wave from a half-second counter. In hybrid mode
// the step rate walks through a fixed table, advancing once per full second.
module pulse_gen_mod #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk100Mhz,
  input  logic       rstN,
  input  logic [1:0] sw32,
  output logic       mode0Clk,
  output logic       mode1Clk
);

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_JOG    = 2'b01,
    MODE_RUN    = 2'b10,
    MODE_HYBRID = 2'b11
  } mode_t;

  localparam logic [31:0] CLK_LIM  = CLK_HZ;
  localparam logic [31:0] HALF_LIM = CLK_HZ / 2;
  localparam logic [3:0]  HS_MAX   = 4'd9;

  mode_t       sync1;
  mode_t       mode;
  mode_t       mode_prev;
  logic        mode_chg;

  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic        acc_wrap;
  logic [7:0]  rate;
  logic [31:0] step;

  logic [31:0] sc;
  logic        sc_wrap;
  logic [3:0]  hs;
  logic        hs_inc;

  // Two-flop synchronizer for the asynchronous mode switch, plus the
  // previous-mode register used to detect a mode change.
  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      sync1     <= MODE_WALK;
      mode      <= MODE_WALK;
      mode_prev <= MODE_WALK;
    end else begin
      sync1     <= mode_t'(sw32);
      mode      <= sync1;
      mode_prev <= mode;
    end
  end

  // Step rate lookup: fixed rates, or the hybrid table indexed by seconds.
  always_comb begin
    rate = 8'd32;
    unique case (mode)
      MODE_WALK: rate = 8'd32;
      MODE_JOG:  rate = 8'd64;
      MODE_RUN:  rate = 8'd128;
      MODE_HYBRID: begin
        case (hs)
          4'd0:    rate = 8'd20;
          4'd1:    rate = 8'd33;
          4'd2:    rate = 8'd66;
          4'd3:    rate = 8'd27;
          4'd4:    rate = 8'd70;
          4'd5:    rate = 8'd30;
          4'd6:    rate = 8'd19;
          4'd7:    rate = 8'd30;
          4'd8:    rate = 8'd33;
          default: rate = 8'd69;
        endcase
      end
    endcase
  end

  // Accumulator arithmetic. acc < CLK_HZ < 2^31 and step <= 256, so the
  // sum never overflows 32 bits.
  always_comb begin
    mode_chg = (mode != mode_prev);
    step     = {23'd0, rate, 1'b0};
    acc_sum  = acc + step;
    acc_wrap = (acc_sum >= CLK_LIM);
    sc_wrap  = (sc == HALF_LIM - 32'd1);
    // A wrap while mode1Clk is high is its falling edge: one full second done.
    hs_inc   = sc_wrap && mode1Clk && (mode == MODE_HYBRID) && (hs != HS_MAX);
  end

  // Phase accumulator and step output; a mode change restarts the phase.
  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      acc      <= 32'd0;
      mode0Clk <= 1'b0;
    end else if (mode_chg) begin
      acc      <= 32'd0;
      mode0Clk <= 1'b0;
    end else if (acc_wrap) begin
      acc      <= acc_sum - CLK_LIM;
      mode0Clk <= ~mode0Clk;
    end else begin
      acc      <= acc_sum;
    end
  end

  // Free-running half-second counter and 1 Hz timebase, independent of mode.
  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      sc       <= 32'd0;
      mode1Clk <= 1'b0;
    end else if (sc_wrap) begin
      sc       <= 32'd0;
      mode1Clk <= ~mode1Clk;
    end else begin
      sc       <= sc + 32'd1;
    end
  end

  // Hybrid seconds index: saturating, restarted by any mode change.
  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      hs <= 4'd0;
    end else if (mode_chg) begin
      hs <= 4'd0;
    end else if (hs_inc) begin
      hs <= hs + 4'd1;
    end
  end

endmodule

// File: tb/tb_pulse_gen_mod.sv
// Directed bench for pulse_gen_mod at CLK_HZ = 1000.
module tb_pulse_gen_mod;

  localparam int CLK_HZ = 1000;

  logic       clk100Mhz = 1'b0;
  logic       rstN      = 1'b0;
  logic [1:0] sw32      = 2'b00;
  logic       mode0Clk;
  logic       mode1Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt;
  logic prev0 = 1'b0;
  int rises = 0;

  typedef struct {
    logic [1:0] sw;
    int         cycles;
    int         exp_rises;
    int         exp_acc;
  } vec_t;

  vec_t vecs[5];
  int   hyb_rate[10];

  pulse_gen_mod #(.CLK_HZ(CLK_HZ)) dut (
    .clk100Mhz(clk100Mhz),
    .rstN     (rstN),
    .sw32     (sw32),
    .mode0Clk (mode0Clk),
    .mode1Clk (mode1Clk)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  // Clock edges since the last reset release.
  always @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) cyc_cnt <= 0;
    else       cyc_cnt <= cyc_cnt + 1;
  end

  task automatic step();
    @(posedge clk100Mhz);
    #1;
    if (!prev0 && mode0Clk) rises++;
    prev0 = mode0Clk;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    n_cmp++;
    if (act < exp - 1 || act > exp + 1) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    end
  endtask

  function automatic int m1_model(input int c);
    return (c / (CLK_HZ / 2)) % 2;
  endfunction

  initial begin
    logic p;
    int   first_tog;
    int   m1_rise;
    int   m1_fall;
    int   found;
    int   win;
    int   idx;

    vecs[0] = '{2'b01, 1000,  64,   0};
    vecs[1] = '{2'b10, 1000, 128,   0};
    vecs[2] = '{2'b00,  500,  16,   0};
    vecs[3] = '{2'b01,  300,  19, 400};
    vecs[4] = '{2'b10,  250,  32,   0};
    hyb_rate = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69};

    // Reset state.
    repeat (3) @(posedge clk100Mhz);
    #1;
    check("rst_m0", int'(mode0Clk), 0);
    check("rst_m1", int'(mode1Clk), 0);
    check("rst_acc", int'(dut.acc), 0);
    check("rst_sc", int'(dut.sc), 0);

    // Walk mode from power-up: first toggle, 1 Hz edge, edge count.
    @(negedge clk100Mhz);
    rstN = 1'b1;
    prev0 = 1'b0;
    rises = 0;
    first_tog = -1;
    m1_rise = -1;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (first_tog < 0 && mode0Clk) first_tog = i;
      if (m1_rise < 0 && mode1Clk) m1_rise = i;
    end
    check("walk_first_toggle", first_tog, 16);
    check("walk_m1_rise", m1_rise, 500);
    check("walk_rises", rises, 32);

    // Table of fixed-rate segments, each started by a mode change.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk100Mhz);
      sw32 = vecs[v].sw;
      repeat (3) step();
      check($sformatf("vec%0d_clr_m0", v), int'(mode0Clk), 0);
      check($sformatf("vec%0d_clr_acc", v), int'(dut.acc), 0);
      prev0 = 1'b0;
      rises = 0;
      for (int i = 0; i < vecs[v].cycles; i++) step();
      check($sformatf("vec%0d_rises", v), rises, vecs[v].exp_rises);
      check($sformatf("vec%0d_acc", v), int'(dut.acc), vecs[v].exp_acc);
      check($sformatf("vec%0d_m1", v), int'(mode1Clk), m1_model(cyc_cnt));
    end

    // Switch run -> walk just after mode0Clk rises.
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      p = mode0Clk;
      step();
      if (!p && mode0Clk) found = 1;
    end
    check("sw_wait_rise", found, 1);
    @(negedge clk100Mhz);
    sw32 = 2'b00;
    step();
    step();
    check("sw_hold_m0", int'(mode0Clk), 1);
    check("sw_hold_acc_nz", int'(dut.acc != 0), 1);
    step();
    check("sw_clr_m0", int'(mode0Clk), 0);
    check("sw_clr_acc", int'(dut.acc), 0);
    check("sw_m1_phase", int'(mode1Clk), m1_model(cyc_cnt));

    // Hybrid mode: per-second edge counts between mode1Clk falling edges.
    found = 0;
    for (int i = 0; i < 1100 && found == 0; i++) begin
      p = mode1Clk;
      step();
      if (!p && mode1Clk) found = 1;
    end
    check("hyb_wait_m1", found, 1);
    @(negedge clk100Mhz);
    sw32 = 2'b11;
    win = 0;
    rises = 0;
    for (int i = 0; i < 12000; i++) begin
      p = mode1Clk;
      step();
      if (p && !mode1Clk) begin
        if (win > 0) begin
          idx = (win > 9) ? 9 : win;
          check_near($sformatf("hyb_sec%0d", win), rises, hyb_rate[idx]);
        end
        win++;
        rises = 0;
      end
    end
    check("hyb_windows", int'(win >= 11), 1);

    // Reset mid-run in hybrid mode with both outputs high.
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      step();
      if (mode0Clk && mode1Clk) found = 1;
    end
    check("rst_wait_high", found, 1);
    @(negedge clk100Mhz);
    rstN = 1'b0;
    #1;
    check("mid_rst_m0", int'(mode0Clk), 0);
    check("mid_rst_m1", int'(mode1Clk), 0);
    check("mid_rst_hs", int'(dut.hs), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk100Mhz);
      #1;
      check($sformatf("in_rst_out%0d", i), int'({mode0Clk, mode1Clk}), 0);
    end
    @(negedge clk100Mhz);
    rstN = 1'b1;
    prev0 = 1'b0;
    rises = 0;
    m1_rise = -1;
    m1_fall = -1;
    for (int i = 1; i <= 1100 && m1_fall < 0; i++) begin
      p = mode1Clk;
      step();
      if (!p && mode1Clk) m1_rise = i;
      if (p && !mode1Clk) m1_fall = i;
    end
    check("post_rst_m1_rise", m1_rise, 500);
    check("post_rst_m1_fall", m1_fall, 1000);
    check_near("post_rst_sec0", rises, 20);
    check("post_rst_hs1", int'(dut.hs), 1);
    rises = 0;
    m1_fall = -1;
    for (int i = 1; i <= 1100 && m1_fall < 0; i++) begin
      p = mode1Clk;
      step();
      if (p && !mode1Clk) m1_fall = i;
    end
    check("post_rst_fall2", m1_fall, 1000);
    check_near("post_rst_sec1", rises, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
